// File: rtl/alu_operand_regfile.sv
// -----------------------------------------------------------------------------
// alu_operand_regfile
//   Operand/result stage around the ALU of the multicycle datapath.
//   Holds an NREG-entry register file (entry 0 reads as zero), the A/B operand
//   latches that feed ALU inputs R2/R3, and the ALUOut/carry latches that
//   capture ALU R1/c_out. Write-back data comes from the ALUOut latch or from
//   an external port. The control unit's enables do all of the sequencing;
//   there is no FSM in this block.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   - an operand latch loaded in the same cycle as a register
//                 write to the same nonzero address receives the new value.
//     undefined - that latch receives the register's old content.
//
// Ports
//   clk        in   1   system clock, all state changes on posedge
//   rst        in   1   synchronous active-high reset, overrides every enable
//   rd_addr_a  in   AW  read address for operand A
//   rd_addr_b  in   AW  read address for operand B
//   ld_ab      in   1   load R2 <= RF[rd_addr_a], R3 <= RF[rd_addr_b]
//   ld_out     in   1   load alu_out <= alu_r1, carry <= alu_c_out
//   alu_r1     in   W   ALU result
//   alu_c_out  in   1   ALU carry out
//   wr_en      in   1   register file write enable
//   wr_addr    in   AW  register file write address
//   wb_src     in   1   write-back source: 0 = alu_out latch, 1 = ext_data
//   ext_data   in   W   external write-back data
//   R2         out  W   operand A latch
//   R3         out  W   operand B latch
//   alu_out    out  W   ALUOut latch
//   carry      out  1   carry flag latch
// -----------------------------------------------------------------------------
module alu_operand_regfile #(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic          ld_ab,
  input  logic          ld_out,
  input  logic [W-1:0]  alu_r1,
  input  logic          alu_c_out,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wb_src,
  input  logic [W-1:0]  ext_data,
  output logic [W-1:0]  R2,
  output logic [W-1:0]  R3,
  output logic [W-1:0]  alu_out,
  output logic          carry
);

  // One extra bit so NREG itself is representable for the range check.
  localparam logic [AW:0] NREG_V = (AW + 1)'(NREG);

  logic [W-1:0] rf_r [NREG];
  logic [W-1:0] wdata_s;
  logic [W-1:0] rd_a_s;
  logic [W-1:0] rd_b_s;
  logic [W-1:0] a_next_s;
  logic [W-1:0] b_next_s;
  logic         wr_ok_s;

  // Address is a real, writable/readable register: nonzero and below NREG.
  function automatic logic addr_live(input logic [AW-1:0] addr);
    return ({1'b0, addr} < NREG_V) && (addr != {AW{1'b0}});
  endfunction

  // Write-back data select and write qualification.
  always_comb begin
    wdata_s = {W{1'b0}};
    wr_ok_s = 1'b0;
    if (wb_src) begin
      wdata_s = ext_data;
    end else begin
      wdata_s = alu_out;
    end
    if (wr_en && addr_live(wr_addr)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Register file read ports; register 0 and out-of-range addresses read zero.
  always_comb begin
    rd_a_s = {W{1'b0}};
    rd_b_s = {W{1'b0}};
    if (addr_live(rd_addr_a)) begin
      rd_a_s = rf_r[rd_addr_a];
    end else begin
      rd_a_s = {W{1'b0}};
    end
    if (addr_live(rd_addr_b)) begin
      rd_b_s = rf_r[rd_addr_b];
    end else begin
      rd_b_s = {W{1'b0}};
    end
  end

  // Operand latch next values, with optional same-cycle write forwarding.
  always_comb begin
    a_next_s = rd_a_s;
    b_next_s = rd_b_s;
`ifdef RF_BYPASS_EN
    if (wr_ok_s && (wr_addr == rd_addr_a)) begin
      a_next_s = wdata_s;
    end else begin
      a_next_s = rd_a_s;
    end
    if (wr_ok_s && (wr_addr == rd_addr_b)) begin
      b_next_s = wdata_s;
    end else begin
      b_next_s = rd_b_s;
    end
`else
    a_next_s = rd_a_s;
    b_next_s = rd_b_s;
`endif
  end

  // All state: register file plus the four output latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_r[i] <= {W{1'b0}};
      end
      R2      <= {W{1'b0}};
      R3      <= {W{1'b0}};
      alu_out <= {W{1'b0}};
      carry   <= 1'b0;
    end else begin
      if (ld_ab) begin
        R2 <= a_next_s;
        R3 <= b_next_s;
      end
      if (ld_out) begin
        alu_out <= alu_r1;
        carry   <= alu_c_out;
      end
      // wdata_s samples alu_out before this edge, so a same-edge ld_out
      // does not feed through to the register file.
      if (wr_ok_s) begin
        rf_r[wr_addr] <= wdata_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_regfile.sv
module tb_alu_operand_regfile;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic          ld_ab, ld_out, alu_c_out, wr_en, wb_src;
  logic [W-1:0]  alu_r1, ext_data;
  logic [W-1:0]  R2, R3, alu_out;
  logic          carry;

  alu_operand_regfile #(.W(W), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .ld_ab(ld_ab), .ld_out(ld_out),
    .alu_r1(alu_r1), .alu_c_out(alu_c_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wb_src(wb_src), .ext_data(ext_data),
    .R2(R2), .R3(R3), .alu_out(alu_out), .carry(carry)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: which output (0=R2 1=R3 2=alu_out 3=carry) and its value.
  typedef struct {
    string       tag;
    int          sel;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [W-1:0] hold_r2, hold_r3, hold_out;
  logic         hold_c;
  logic [W:0]   sum;
  logic [W-1:0] hz_exp;

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      0:       return R2;
      1:       return R3;
      2:       return alu_out;
      3:       return {{(W-1){1'b0}}, carry};
      default: return {W{1'bx}};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [W-1:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_all(input string tag, input logic [W-1:0] r2, input logic [W-1:0] r3,
                            input logic [W-1:0] ao, input logic c);
    expect_out({tag, "_R2"}, 0, r2);
    expect_out({tag, "_R3"}, 1, r3);
    expect_out({tag, "_aluout"}, 2, ao);
    expect_out({tag, "_carry"}, 3, {{(W-1){1'b0}}, c});
  endtask

  // Clock edge, then drain the scoreboard against the settled outputs.
  task automatic tick();
    exp_t e;
    logic [W-1:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    rst = 1'b0; ld_ab = 1'b0; ld_out = 1'b0; wr_en = 1'b0; wb_src = 1'b0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; wr_addr = 3'd0;
    alu_r1 = 16'h0000; alu_c_out = 1'b0; ext_data = 16'h0000;
  endtask

  task automatic wr_ext(input logic [AW-1:0] a, input logic [W-1:0] d);
    idle();
    wr_en = 1'b1; wr_addr = a; wb_src = 1'b1; ext_data = d;
    tick();
  endtask

  initial begin
    idle();
    // Reset from power-up.
    rst = 1'b1;
    expect_all("por", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick();

    // Fill RF[1..7] = i and read each back with b on a mirrored address.
    for (int i = 1; i < 8; i++) wr_ext(AW'(i), W'(i));
    for (int i = 1; i < 8; i++) begin
      idle();
      ld_ab = 1'b1; rd_addr_a = AW'(i); rd_addr_b = AW'(8 - i);
      expect_out("fill_R2", 0, W'(i));
      expect_out("fill_R3", 1, W'(8 - i));
      tick();
    end
    idle();
    ld_out = 1'b1; alu_r1 = 16'h5A5A; alu_c_out = 1'b1;
    expect_out("preload_aluout", 2, 16'h5A5A);
    expect_out("preload_carry", 3, 16'h0001);
    tick();

    // Single-cycle reset clears RF and latches.
    idle(); rst = 1'b1;
    expect_all("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      idle();
      ld_ab = 1'b1; rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      expect_out("rst_rd_R2", 0, 16'h0000);
      expect_out("rst_rd_R3", 1, 16'h0000);
      tick();
    end

    // Register 0 ignores writes.
    wr_ext(3'd0, 16'hBEEF);
    idle(); ld_ab = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    expect_out("r0_R2", 0, 16'h0000);
    tick();

    // Operand path and ALU add model.
    wr_ext(3'd3, 16'hFFFF);
    wr_ext(3'd4, 16'h0001);
    idle(); ld_ab = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd4;
    expect_out("op_R2", 0, 16'hFFFF);
    expect_out("op_R3", 1, 16'h0001);
    tick();
    sum = {1'b0, 16'hFFFF} + {1'b0, 16'h0001};
    idle(); ld_out = 1'b1; alu_r1 = sum[W-1:0]; alu_c_out = sum[W];
    expect_out("add_aluout", 2, 16'h0000);
    expect_out("add_carry", 3, 16'h0001);
    tick();

    // Write-back from alu_out; carry untouched by wr_en.
    idle(); wr_en = 1'b1; wr_addr = 3'd5; wb_src = 1'b0; ext_data = 16'h7777;
    expect_out("wb_carry", 3, 16'h0001);
    tick();
    idle(); ld_ab = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd3;
    expect_out("wb_R2", 0, 16'h0000);
    expect_out("wb_R3", 1, 16'hFFFF);
    tick();

    // Same-edge ld_out + write-back stores the old alu_out.
    idle(); ld_out = 1'b1; alu_r1 = 16'h1234; alu_c_out = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd6; wb_src = 1'b0;
    expect_out("wbsame_aluout", 2, 16'h1234);
    expect_out("wbsame_carry", 3, 16'h0000);
    tick();
    idle(); wr_en = 1'b1; wr_addr = 3'd7; wb_src = 1'b0;
    tick();
    idle(); ld_ab = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd7;
    expect_out("wbold_R2", 0, 16'h0000);
    expect_out("wbnew_R3", 1, 16'h1234);
    tick();

    // Same-cycle write/read hazard on register 2, both ports.
    wr_ext(3'd2, 16'h1111);
`ifdef RF_BYPASS_EN
    hz_exp = 16'h2222;
`else
    hz_exp = 16'h1111;
`endif
    idle(); wr_en = 1'b1; wr_addr = 3'd2; wb_src = 1'b1; ext_data = 16'h2222;
    ld_ab = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    expect_out("hazard_R2", 0, hz_exp);
    expect_out("hazard_R3", 1, hz_exp);
    tick();
    idle(); ld_ab = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd4;
    expect_out("hazard_next_R2", 0, 16'h2222);
    expect_out("hazard_next_R3", 1, 16'h0001);
    tick();

    // Hold for 10 cycles while other inputs wiggle.
    idle(); ld_ab = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    ld_out = 1'b1; alu_r1 = 16'hC3C3; alu_c_out = 1'b1;
    hold_r2 = 16'hFFFF; hold_r3 = 16'h1234; hold_out = 16'hC3C3; hold_c = 1'b1;
    expect_all("hold_load", hold_r2, hold_r3, hold_out, hold_c);
    tick();
    for (int i = 0; i < 10; i++) begin
      idle();
      rd_addr_a = AW'(i); rd_addr_b = AW'(i + 1);
      alu_r1 = W'($urandom); alu_c_out = 1'b0;
      expect_all("hold", hold_r2, hold_r3, hold_out, hold_c);
      tick();
    end

    // Reset wins over every enable on the same edge.
    idle(); rst = 1'b1; ld_out = 1'b1; alu_r1 = 16'hABCD; alu_c_out = 1'b1;
    ld_ab = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd1; wb_src = 1'b1; ext_data = 16'h9999;
    expect_all("midrst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick();
    idle(); ld_ab = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    expect_out("midrst_rf1", 0, 16'h0000);
    expect_out("midrst_rf3", 1, 16'h0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
